// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode seven-segment
// digits that share one decoder. Each digit slot lasts DIV cycles. The first
// BLANK cycles of a slot keep every anode off to suppress ghosting. Display
// data is double-buffered: a load writes the shadow buffer, and the shadow is
// copied to the active buffer only at a frame boundary.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | scanning stopped, all anodes off, decoder inputs held at zero
// ST_BLANK | start of a digit slot, anodes off, decoder already fed digit idx
// ST_DRIVE | anode idx on, decoder fed the active nibble/dp of digit idx

module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV        = 50000,
   parameter int BLANK      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [3:0]              hex,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    load_ack,
   output logic                    frame_start
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
   // With BLANK == 0 the blank state is never entered, so this value is unused.
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   // A slot opens in the blank state unless there is no blanking interval.
   localparam state_t SLOT_FIRST = (BLANK == 0) ? ST_DRIVE : ST_BLANK;

   state_t                  state, state_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic                    boundary;

   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [4*NUM_DIGITS-1:0] active_val;
   logic [NUM_DIGITS-1:0]   active_dp;
   logic                    pending;
   logic                    load_ack_q;
   logic                    frame_start_q;

   // Next-state logic: slot timing, digit advance and frame-boundary detection.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      boundary  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (en) begin
               boundary  = 1'b1;
               idx_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = SLOT_FIRST;
            end
         end
         ST_BLANK: begin
            if (!en) begin
               idx_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
               if (cnt == BLANK_LAST) begin
                  state_nxt = ST_DRIVE;
               end
            end
         end
         ST_DRIVE: begin
            if (!en) begin
               idx_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = SLOT_FIRST;
               if (idx == IDX_LAST) begin
                  idx_nxt  = '0;
                  boundary = 1'b1;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            idx_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counters and data buffers. The boundary copy reads the shadow
   // value from before this edge, so a load landing on a boundary stays
   // pending for the following frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         idx           <= '0;
         cnt           <= '0;
         shadow_val    <= '0;
         shadow_dp     <= '0;
         active_val    <= '0;
         active_dp     <= '0;
         pending       <= 1'b0;
         load_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         cnt           <= cnt_nxt;
         frame_start_q <= boundary;
         load_ack_q    <= boundary && pending;
         if (boundary && pending) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
         end
         if (load) begin
            shadow_val <= value_in;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
         end else if (boundary) begin
            pending <= 1'b0;
         end
      end
   end

   // Output decode from registered state only.
   always_comb begin
      an  = '1;
      hex = '0;
      dp  = 1'b0;
      unique case (state)
         ST_BLANK: begin
            hex = active_val[int'(idx)*4 +: 4];
            dp  = active_dp[idx];
         end
         ST_DRIVE: begin
            hex     = active_val[int'(idx)*4 +: 4];
            dp      = active_dp[idx];
            an[idx] = 1'b0;
         end
         default: begin
            an  = '1;
            hex = '0;
            dp  = 1'b0;
         end
      endcase
   end

   assign load_ack    = load_ack_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl. A frame-position reference model
// predicts the outputs that follow each clock edge; predictions pass through
// a scoreboard queue and are compared after the edge.

module tb_seven_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int DV    = 6;
   localparam int BL    = 2;
   localparam int FRAME = ND * DV;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  hex;
   logic        dp;
   logic [3:0]  an;
   logic        load_ack;
   logic        frame_start;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS(ND),
      .DIV       (DV),
      .BLANK     (BL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load       (load),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .hex        (hex),
      .dp         (dp),
      .an         (an),
      .load_ack   (load_ack),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] hex;
      logic       dp;
      logic       ack;
      logic       fs;
   } exp_t;

   exp_t sbq[$];
   int   checks    = 0;
   int   failures  = 0;
   int   ack_seen  = 0;

   // reference model: position within the frame rather than a state machine
   logic        m_run  = 1'b0;
   int          m_pos  = 0;
   logic [15:0] m_shv  = '0;
   logic [3:0]  m_shd  = '0;
   logic [15:0] m_acv  = '0;
   logic [3:0]  m_acd  = '0;
   logic        m_pend = 1'b0;
   logic        m_ack  = 1'b0;
   logic        m_fs   = 1'b0;

   function automatic exp_t model_out();
      exp_t o;
      int   digit;
      int   c;
      o = '{an: 4'hF, hex: 4'h0, dp: 1'b0, ack: m_ack, fs: m_fs};
      if (m_run) begin
         digit = m_pos / DV;
         c     = m_pos % DV;
         o.hex = m_acv[digit*4 +: 4];
         o.dp  = m_acd[digit];
         if (c >= BL) o.an = ~(4'b0001 << digit);
      end
      return o;
   endfunction

   task automatic model_edge(input logic r, input logic e, input logic l,
                             input logic [15:0] v, input logic [3:0] d);
      logic bnd;
      bnd = r && e && (!m_run || m_pos == FRAME - 1);
      if (!r) begin
         m_run = 0; m_pos = 0; m_shv = '0; m_shd = '0; m_acv = '0; m_acd = '0;
         m_pend = 0; m_ack = 0; m_fs = 0;
      end else begin
         m_ack = bnd && m_pend;
         if (m_ack) begin
            m_acv = m_shv;
            m_acd = m_shd;
         end
         m_fs = bnd;
         if (l) begin
            m_shv  = v;
            m_shd  = d;
            m_pend = 1'b1;
         end else if (m_ack) begin
            m_pend = 1'b0;
         end
         if (!e)       m_pos = 0;
         else if (bnd) m_pos = 0;
         else          m_pos = m_pos + 1;
         m_run = e;
      end
   endtask

   task automatic step(input logic r, input logic e, input logic l,
                       input logic [15:0] v, input logic [3:0] d);
      exp_t want;
      rst_n    = r;
      en       = e;
      load     = l;
      value_in = v;
      dp_in    = d;
      model_edge(r, e, l, v, d);
      sbq.push_back(model_out());
      @(posedge clk);
      #1;
      want = sbq.pop_front();
      checks++;
      assert ({an, hex, dp} === {want.an, want.hex, want.dp}) else begin
         failures++;
         $display("FAIL display t=%0t observed an=%b hex=%h dp=%b expected an=%b hex=%h dp=%b",
                  $time, an, hex, dp, want.an, want.hex, want.dp);
         $error("display mismatch");
      end
      checks++;
      assert ({load_ack, frame_start} === {want.ack, want.fs}) else begin
         failures++;
         $display("FAIL pulses t=%0t observed ack=%b fs=%b expected ack=%b fs=%b",
                  $time, load_ack, frame_start, want.ack, want.fs);
         $error("pulse mismatch");
      end
      if (load_ack === 1'b1) ack_seen++;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, got, expv);
         $error("directed check mismatch");
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
   endtask

   // Run scanning until the model sits at frame position p (bounded).
   task automatic run_until(input int p);
      int n;
      n = 0;
      while (m_pos != p && n < 2 * FRAME) begin
         step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
         n++;
      end
      checks++;
      if (m_pos != p) begin
         failures++;
         $display("FAIL run_until observed pos=%0d expected pos=%0d", m_pos, p);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; load = 1'b0; value_in = '0; dp_in = '0;

      // 1: reset dominates en/load, then idle with en low
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'hFFFF, 4'hF);
      chk("reset_an", 32'(an), 32'hF);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      chk("idle_an", 32'(an), 32'hF);
      chk("idle_hex", 32'(hex), 32'h0);

      // 2: load in idle, then start scanning
      step(1'b1, 1'b0, 1'b1, 16'h1234, 4'b0001);
      step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      ack_seen = 0;
      step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      chk("first_ack", 32'(load_ack), 32'h1);
      chk("first_fs", 32'(frame_start), 32'h1);
      chk("first_hex", 32'({hex, dp}), 32'h9);
      run_cycles(2);
      chk("d0_drive_an", 32'(an), 32'hE);

      // 3: load mid-frame (digit 1 slot) appears only next frame
      run_until(7);
      step(1'b1, 1'b1, 1'b1, 16'hABCD, 4'b0000);
      run_until(15);
      chk("old_d2_hex", 32'(hex), 32'h2);
      run_until(23);
      step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      chk("ack_abcd", 32'(ack_seen), 32'd2);
      chk("new_d0_hex", 32'(hex), 32'hD);

      // 4: two loads in one frame give one ack
      run_until(4);
      step(1'b1, 1'b1, 1'b1, 16'h0001, 4'b0010);
      run_until(16);
      step(1'b1, 1'b1, 1'b1, 16'h00F0, 4'b0000);
      ack_seen = 0;
      run_until(23);
      step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      run_until(23);
      chk("single_ack", 32'(ack_seen), 32'd1);

      // 5: load coincident with a frame boundary
      run_until(10);
      step(1'b1, 1'b1, 1'b1, 16'h5A5A, 4'b1010);
      run_until(23);
      ack_seen = 0;
      step(1'b1, 1'b1, 1'b1, 16'h9876, 4'b0100);
      chk("bnd_hex_old", 32'(hex), 32'hA);
      run_until(23);
      step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      chk("bnd_hex_new", 32'(hex), 32'h6);
      chk("bnd_acks", 32'(ack_seen), 32'd2);

      // 6: en drop mid-drive of digit 2, restart without pending data
      ack_seen = 0;
      run_until(14);
      step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      chk("stop_an", 32'(an), 32'hF);
      chk("stop_hex", 32'(hex), 32'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
      chk("restart_fs", 32'(frame_start), 32'h1);
      chk("restart_an", 32'(an), 32'hF);
      run_until(23);
      chk("restart_no_ack", 32'(ack_seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one Seven_Seg decoder instance across NUM_DIGITS common-anode digits. Each cycle it presents one digit's nibble and decimal point on the decoder's hex/dp inputs and drives the active-low digit enables. A blanking interval at the start of each digit slot suppresses ghosting. Display data is double-buffered: new values load into a shadow register and become visible only at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
DIV, 50000, clock cycles per digit slot (>=2)
BLANK, 8, cycles at slot start with all digits off (0 <= BLANK < DIV)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  scan enable
load  in  1  1-cycle strobe; capture value_in/dp_in into shadow
value_in  in  4*NUM_DIGITS  digit nibbles; digit i = value_in[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point per digit, active-high
hex  out  4  to Seven_Seg.hex
dp  out  1  to Seven_Seg.dp
an  out  NUM_DIGITS  digit enables, active-low
load_ack  out  1  1-cycle pulse: shadow copied to active buffer
frame_start  out  1  1-cycle pulse: digit 0 slot begins

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, idx=0, cnt=0, shadow=0, active=0, pending=0. Outputs: an=all 1s, hex=0, dp=0, load_ack=0, frame_start=0. Reset overrides all other inputs. An rst_n low pulse not spanning a rising edge has no effect.
- States: IDLE, BLANK, DRIVE. All outputs are decoded from registered state only.
- IDLE: an=all 1s, hex=0, dp=0. If en=1 → frame boundary, idx<=0, cnt<=0, next state BLANK (DRIVE if BLANK=0).
- BLANK: an=all 1s. hex/dp already show active[idx]. cnt++. At cnt==BLANK-1 → DRIVE.
- DRIVE: an[idx]=0, all others 1. hex=active nibble idx, dp=active dp bit idx. cnt++.
  - At cnt==DIV-1: cnt<=0 and next state BLANK (DRIVE if BLANK=0).
  - If idx==NUM_DIGITS-1: idx<=0 and frame boundary. Otherwise idx++.
- Slot length: exactly DIV cycles, with BLANK off-cycles then DIV-BLANK on-cycles. Frame length: NUM_DIGITS*DIV cycles.
- en=0 in BLANK/DRIVE: next state IDLE, idx<=0, cnt<=0. The partial frame is abandoned and no transfer occurs.
- Frame boundary:
  - frame_start=1 for exactly the first cycle of the new BLANK/DRIVE.
  - If pending=1: active<=shadow, pending<=0, load_ack=1 for that same cycle.
- load=1 (any state): shadow<=value_in/dp_in, pending<=1. A later load before the boundary overwrites shadow; only one ack is issued.
- load in the same cycle as a frame boundary: the transfer uses the pre-edge shadow. The new data goes into shadow with pending=1 and is transferred at the next boundary.
- load while IDLE: data is held until en rises. The first frame then shows it and load_ack pulses.

Test Plan:
(Bench parameters: NUM_DIGITS=4, DIV=6, BLANK=2.)
1. Reset: rst_n=0 for 3 edges with en=1, load=1 → an=4'b1111, hex=0, dp=0, load_ack=0, frame_start=0. After release with en=0 → stays IDLE.
2. In IDLE: load value_in=16'h1234, dp_in=4'b0001; then en=1 → next cycle load_ack=1 and frame_start=1. Digit 0: hex=4, dp=1, an=1111 for 2 cycles then 1110 for 4. Digit 1: hex=3, dp=0, an=1101. Digit 2: hex=2, an=1011. Digit 3: hex=1, an=0111. frame_start repeats every 24 cycles.
3. During the digit 1 slot of the 1234 frame, load 16'hABCD → digits 2 and 3 still show 2 and 1. load_ack pulses with the next frame_start. The next frame's digit 0 shows hex=D.
4. Two loads in one frame (16'h0001, then 16'h00F0) → exactly one load_ack. The next frame shows digits 0,F,0,0.
5. Load coincident with a frame boundary → ack for the old pending data only (if any). The new data appears one frame later with a second ack.
6. en=0 mid-DRIVE of digit 2 → next cycle an=1111, hex=0. en=1 again → frame_start, digit 0 with BLANK first. No load_ack without a pending load.
